// File: rtl/oled_cmd_sequencer.sv
// Programmable SSD1331 command-sequence engine: plays typed table entries (CMD/DATA/DELAY/END)
// from base_addr as a valid/ready byte stream. Define OLED_SEQ_DELAY_EN to enable timed DELAY entries.
module oled_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int DELAY_UNIT = 100000,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH+1:0] wr_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_dc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] KIND_CMD   = 2'b00;
  localparam logic [1:0] KIND_DATA  = 2'b01;
  localparam logic [1:0] KIND_DELAY = 2'b10;
  localparam logic [1:0] KIND_END   = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
`ifdef OLED_SEQ_DELAY_EN
    WAIT  = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       ptr_reg, ptr_next;
  logic                    m_valid_reg, m_valid_next;
  logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
  logic                    m_dc_reg, m_dc_next;
  logic                    err_reg, err_next;
  logic                    advance;

  logic [DATA_WIDTH+1:0]   table_mem [DEPTH];
  logic [DATA_WIDTH+1:0]   entry;
  logic [1:0]              entry_kind;
  logic [DATA_WIDTH-1:0]   entry_payload;
  logic                    wr_ok;

  assign entry         = table_mem[ptr_reg];
  assign entry_kind    = entry[DATA_WIDTH+1:DATA_WIDTH];
  assign entry_payload = entry[DATA_WIDTH-1:0];
  assign wr_ok         = rst_n && wr_en && (state_reg == IDLE);

`ifdef OLED_SEQ_DELAY_EN
  // Counter sized for the largest payload times DELAY_UNIT, so the product never truncates.
  localparam longint MAX_CNT = ((longint'(1) << DATA_WIDTH) - 1) * longint'(DELAY_UNIT);
  localparam int     CNT_W   = $clog2(MAX_CNT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next, delay_cycles;
  assign delay_cycles = CNT_W'(entry_payload) * CNT_W'(DELAY_UNIT);
`endif

  // Table contents survive reset, except entry 0 which becomes END (empty sequence).
  always_ff @(posedge clk) begin
    if (wr_ok) table_mem[wr_addr] <= wr_data;
    if (!rst_n) table_mem[0] <= {KIND_END, {DATA_WIDTH{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_dc_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef OLED_SEQ_DELAY_EN
      cnt_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_dc_reg    <= m_dc_next;
      err_reg     <= err_next;
`ifdef OLED_SEQ_DELAY_EN
      cnt_reg     <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_dc_next    = m_dc_reg;
    err_next     = err_reg;
    advance      = 1'b0;
`ifdef OLED_SEQ_DELAY_EN
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          ptr_next   = base_addr;
          err_next   = 1'b0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        case (entry_kind)
          KIND_CMD, KIND_DATA: begin
            m_data_next  = entry_payload;
            m_dc_next    = entry_kind[0];
            m_valid_next = 1'b1;
            state_next   = SEND;
          end
          KIND_DELAY: begin
`ifdef OLED_SEQ_DELAY_EN
            if (delay_cycles == '0) begin
              advance = 1'b1;
            end else begin
              cnt_next   = delay_cycles;
              state_next = WAIT;
            end
`else
            advance = 1'b1;
`endif
          end
          default: state_next = DONE;
        endcase
      end
      SEND: begin
        if (m_ready) begin
          m_valid_next = 1'b0;
          advance      = 1'b1;
        end
      end
`ifdef OLED_SEQ_DELAY_EN
      WAIT: begin
        if (cnt_reg == CNT_W'(1)) begin
          cnt_next = '0;
          advance  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Running off the last entry is an error rather than a wrap-around.
    if (advance) begin
      if (ptr_reg == LAST_ADDR) begin
        err_next   = 1'b1;
        state_next = DONE;
      end else begin
        ptr_next   = ptr_reg + ADDR_W'(1);
        state_next = FETCH;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_dc    = m_dc_reg;
  assign err     = err_reg;
  assign done    = (state_reg == DONE);
`ifdef OLED_SEQ_DELAY_EN
  assign busy    = (state_reg == FETCH) || (state_reg == SEND) || (state_reg == WAIT);
`else
  assign busy    = (state_reg == FETCH) || (state_reg == SEND);
`endif

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Directed bench for oled_cmd_sequencer; delay-gap expectation follows OLED_SEQ_DELAY_EN.
module tb_oled_cmd_sequencer;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int DU    = 4;
`ifdef OLED_SEQ_DELAY_EN
  localparam int GAP = 3 * DU + 2;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          wr_en = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW+1:0] wr_data = '0;
  logic          m_valid, m_dc, busy, done, err;
  logic [DW-1:0] m_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_err = 0;
  int done_busy = 0;
  logic mv_prev = 1'b0;
  logic [DW:0] hs_data[$];
  int hs_cyc[$];
  int vrise_cyc[$];

  oled_cmd_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DELAY_UNIT(DU)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dc(m_dc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: logs each handshake, each m_valid rise and each done pulse.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      hs_data.push_back({m_dc, m_data});
      hs_cyc.push_back(cyc);
      $display("[%0d] byte dc=%0d data=%02h", cyc, m_dc, m_data);
    end
    if (rst_n && m_valid && !mv_prev) vrise_cyc.push_back(cyc);
    mv_prev = m_valid;
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_err  = int'(err);
      done_busy = int'(busy);
      $display("[%0d] done err=%0d", cyc, err);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [1:0] kind, input logic [DW-1:0] payload);
    wr_addr = AW'(addr);
    wr_data = {kind, payload};
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input int base);
    hs_data.delete();
    hs_cyc.delete();
    vrise_cyc.delete();
    done_cnt  = 0;
    base_addr = AW'(base);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) tick();
    tick();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_done_busy"}, done_busy, 0);
  endtask

  initial begin
    int start_cyc;
    tick();
    tick();
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_dc", int'(m_dc), 0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();

    // Empty table after reset: entry 0 is END.
    do_start(0);
    wait_done("empty", 20);
    check("empty_bytes", hs_data.size(), 0);

    // Basic stream FD,12,5A.
    write_entry(0, 2'b00, 8'hFD);
    write_entry(1, 2'b00, 8'h12);
    write_entry(2, 2'b01, 8'h5A);
    write_entry(3, 2'b11, 8'h00);
    do_start(0);
    start_cyc = cyc;
    check("t1_busy_after_start", int'(busy), 1);
    check("t1_no_valid_yet", int'(m_valid), 0);
    wait_done("t1", 100);
    check("t1_nbytes", hs_data.size(), 3);
    check("t1_b0", int'(hs_data[0]), 9'h0FD);
    check("t1_b1", int'(hs_data[1]), 9'h012);
    check("t1_b2", int'(hs_data[2]), 9'h15A);
    check("t1_latency", vrise_cyc[0] - start_cyc, 1);
    check("t1_spacing01", hs_cyc[1] - hs_cyc[0], 2);
    check("t1_spacing12", hs_cyc[2] - hs_cyc[1], 2);
    check("t1_err", done_err, 0);

    // Backpressure on byte 2.
    do_start(0);
    for (int i = 0; i < 50 && hs_data.size() < 1; i++) tick();
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", int'(m_valid), 1);
      check("t2_hold_data", int'(m_data), 8'h12);
      check("t2_hold_dc", int'(m_dc), 0);
      tick();
    end
    check("t2_stalled_count", hs_data.size(), 1);
    m_ready = 1'b1;
    wait_done("t2", 100);
    check("t2_nbytes", hs_data.size(), 3);
    check("t2_b1", int'(hs_data[1]), 9'h012);

    // Delay entry between two commands.
    write_entry(4, 2'b00, 8'hAE);
    write_entry(5, 2'b10, 8'd3);
    write_entry(6, 2'b00, 8'hAF);
    write_entry(7, 2'b11, 8'h00);
    do_start(4);
    wait_done("t3", 200);
    check("t3_nbytes", hs_data.size(), 2);
    check("t3_b1", int'(hs_data[1]), 9'h0AF);
    check("t3_gap", vrise_cyc[1] - hs_cyc[0], GAP + 1);

    // Run off the end of the table.
    write_entry(DEPTH - 2, 2'b00, 8'h01);
    write_entry(DEPTH - 1, 2'b00, 8'h02);
    do_start(DEPTH - 2);
    wait_done("t4", 100);
    check("t4_nbytes", hs_data.size(), 2);
    check("t4_b0", int'(hs_data[0]), 9'h001);
    check("t4_b1", int'(hs_data[1]), 9'h002);
    check("t4_err_at_done", done_err, 1);
    check("t4_err_sticky", int'(err), 1);
    do_start(0);
    check("t4_err_cleared", int'(err), 0);
    wait_done("t4b", 100);
    check("t4b_err", done_err, 0);

    // start and wr_en while busy are ignored.
    do_start(4);
    tick();
    tick();
    check("t5_busy", int'(busy), 1);
    base_addr = AW'(0);
    start     = 1'b1;
    wr_addr   = AW'(6);
    wr_data   = {2'b00, 8'h77};
    wr_en     = 1'b1;
    tick();
    start     = 1'b0;
    wr_en     = 1'b0;
    wait_done("t5", 200);
    check("t5_b1", int'(hs_data[1]), 9'h0AF);
    tick();
    tick();
    check("t5_no_restart", int'(busy), 0);
    check("t5_no_restart_done", done_cnt, 1);
    do_start(4);
    wait_done("t5rb", 200);
    check("t5_readback", int'(hs_data[1]), 9'h0AF);

    // Reset mid-sequence.
    m_ready = 1'b0;
    do_start(0);
    tick();
    check("t6_valid_before", int'(m_valid), 1);
    rst_n = 1'b0;
    tick();
    check("t6_valid_drop", int'(m_valid), 0);
    check("t6_busy_drop", int'(busy), 0);
    check("t6_data_clr", int'(m_data), 0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    do_start(0);
    wait_done("t6", 20);
    check("t6_bytes", hs_data.size(), 0);
    check("t6_err", done_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
